// File: rtl/xor_stream_descrambler_pkg.sv
// xor_stream_descrambler_pkg
//
// Purpose: constants and the keystream advance function shared by the
// descrambler and the upstream scrambler, so both ends regenerate exactly
// the same 32-bit Galois LFSR keystream.
//
// Contents:
//   WORD_W        - data word and LFSR width (32)
//   LFSR_POLY     - Galois tap mask for x^32+x^22+x^2+x+1
//   LFSR_ZERO_SUB - state used in place of an all-zero seed
//   lfsr_adv32()  - advance an LFSR state by 32 Galois steps
package xor_stream_descrambler_pkg;

    localparam int                WORD_W        = 32;
    localparam logic [WORD_W-1:0] LFSR_POLY     = 32'h80200003;
    localparam logic [WORD_W-1:0] LFSR_ZERO_SUB = 32'h00000001;

    // One keystream word consumes 32 shift steps; each step shifts right and
    // folds the tap mask in whenever a one falls out of the low end.
    function automatic logic [WORD_W-1:0] lfsr_adv32(
        input logic [WORD_W-1:0] state,
        input logic [WORD_W-1:0] poly
    );
        logic [WORD_W-1:0] s;
        s = state;
        for (int i = 0; i < WORD_W; i++) begin
            if (s[0]) begin
                s = (s >> 1) ^ poly;
            end else begin
                s = s >> 1;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/lfsr32_keygen.sv
// lfsr32_keygen
//
// Purpose: owns the 32-bit keystream LFSR. Loads a seed (with zero
// substitution, since the all-zero state never leaves zero) and advances
// by one full keystream word whenever enabled.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset, state returns to LFSR_ZERO_SUB
//   load  in   load seed this cycle (wins over adv)
//   seed  in   32-bit seed value
//   adv   in   advance the state by 32 Galois steps
//   lfsr  out  current keystream word (state before any advance)
module lfsr32_keygen
    import xor_stream_descrambler_pkg::*;
#(
    parameter logic [WORD_W-1:0] POLY = LFSR_POLY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] seed,
    input  logic              adv,
    output logic [WORD_W-1:0] lfsr
);

    logic [WORD_W-1:0] lfsr_q;
    logic [WORD_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? LFSR_ZERO_SUB : seed;
        end else if (adv) begin
            lfsr_d = lfsr_adv32(lfsr_q, POLY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_ZERO_SUB;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/xor_stream_descrambler.sv
// xor_stream_descrambler
//
// Purpose: recovers plaintext from a word stream that was XORed with an LFSR
// keystream upstream. Each accepted word is XORed with the current keystream
// word and presented through a single registered valid/ready output stage.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   seed_load   in   load seed into the keystream generator; blocks input
//   seed        in   keystream seed
//   in_valid    in   in_data valid
//   in_ready    out  word accepted this cycle when in_valid is also high
//   in_data     in   scrambled word
//   out_valid   out  out_data valid
//   out_ready   in   consumer takes out_data
//   out_data    out  descrambled word
//   word_count  out  words accepted since reset/seed load (saturating)
//
// Build option: define DESCRAMBLER_WORD_COUNT_EN to build the word counter;
// without it word_count is tied to zero. Data behaviour is the same.
module xor_stream_descrambler
    import xor_stream_descrambler_pkg::*;
#(
    parameter int                WIDTH = 32,
    parameter logic [WORD_W-1:0] POLY  = LFSR_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      word_count
);

    logic              accept;
    logic [WORD_W-1:0] key;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [WIDTH-1:0]  out_data_q;
    logic [WIDTH-1:0]  out_data_d;

    // Input is stalled during a seed load so no word ever straddles two seeds,
    // and otherwise whenever the output register cannot be refilled.
    assign in_ready = !seed_load && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    lfsr32_keygen #(
        .POLY (POLY)
    ) u_keygen (
        .clk  (clk),
        .rst  (rst),
        .load (seed_load),
        .seed (seed),
        .adv  (accept),
        .lfsr (key)
    );

    // A new word replaces the register even while the old one retires, which
    // keeps full-rate streaming bubble-free.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = in_data ^ key;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef DESCRAMBLER_WORD_COUNT_EN
    logic [15:0] word_count_q;
    logic [15:0] word_count_d;

    // Count restarts with each seed so it tracks position in the keystream.
    always_comb begin
        word_count_d = word_count_q;
        if (seed_load) begin
            word_count_d = '0;
        end else if (accept && (word_count_q != 16'hFFFF)) begin
            word_count_d = word_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_q <= '0;
        end else begin
            word_count_q <= word_count_d;
        end
    end

    assign word_count = word_count_q;
`else
    assign word_count = 16'h0000;
`endif

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// tb_xor_stream_descrambler
//
// Purpose: self-checking bench for xor_stream_descrambler. A behavioural
// model of the handshake and keystream runs alongside the DUT, and a separate
// scrambler model produces ciphertext for the round-trip test.
// Follows DESCRAMBLER_WORD_COUNT_EN for the expected word_count.
module tb_xor_stream_descrambler;

    localparam logic [31:0] POLY = 32'h80200003;

    logic        clk = 1'b0;
    logic        rst;
    logic        seedLoad;
    logic [31:0] seed;
    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [15:0] wordCount;

    int errorCount = 0;
    int checkCount = 0;

    // Reference model state
    logic [31:0] mKey;
    logic        mValid;
    logic [31:0] mData;
    int          mCount;

    logic [31:0] plain  [1000];
    logic [31:0] cipher [1000];

    xor_stream_descrambler #(
        .WIDTH (32),
        .POLY  (POLY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seedLoad),
        .seed       (seed),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_data    (inData),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_data   (outData),
        .word_count (wordCount)
    );

    always #5 clk = ~clk;

    // Next keystream word: 32 single-bit steps done with plain arithmetic.
    function automatic logic [31:0] refAdvance(input logic [31:0] s);
        longint unsigned v;
        logic [31:0] r;
        v = longint'(s);
        for (int i = 0; i < 32; i++) begin
            if (v % 2 == 1) v = (v / 2) ^ longint'(POLY);
            else            v = v / 2;
        end
        r = v[31:0];
        return r;
    endfunction

    function automatic logic [15:0] expCount();
`ifdef DESCRAMBLER_WORD_COUNT_EN
        return 16'(mCount);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // One clock cycle: drive, check ready, clock, update model, check outputs.
    task automatic applyStimulus(input logic r, input logic sl, input logic [31:0] sd,
                                 input logic iv, input logic [31:0] id, input logic ordy);
        logic expReady;
        logic acc;
        rst = r; seedLoad = sl; seed = sd; inValid = iv; inData = id; outReady = ordy;
        #1;
        expReady = !sl && (!mValid || ordy);
        checkOutput("in_ready", {31'd0, inReady}, {31'd0, expReady});
        acc = iv && expReady;
        @(posedge clk);
        if (r) begin
            mKey = 32'h1; mValid = 1'b0; mData = '0; mCount = 0;
        end else if (sl) begin
            mKey   = (sd == 0) ? 32'h1 : sd;
            mCount = 0;
            if (mValid && ordy) mValid = 1'b0;
        end else if (acc) begin
            mData  = id ^ mKey;
            mValid = 1'b1;
            mKey   = refAdvance(mKey);
            if (mCount < 65535) mCount++;
        end else if (mValid && ordy) begin
            mValid = 1'b0;
        end
        #1;
        checkOutput("out_valid", {31'd0, outValid}, {31'd0, mValid});
        checkOutput("out_data", outData, mData);
        checkOutput("word_count", {16'd0, wordCount}, {16'd0, expCount()});
    endtask

    initial begin
        logic [31:0] key;
        logic [31:0] held;
        logic [31:0] w;

        mKey = 32'h1; mValid = 1'b0; mData = '0; mCount = 0;
        rst = 1'b1; seedLoad = 1'b0; seed = '0; inValid = 1'b0; inData = '0; outReady = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_valid", {31'd0, outValid}, 32'd0);

        // Known vector with seed A5A5A5A5
        applyStimulus(0, 1, 32'hA5A5A5A5, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 32'hFFFFFFFF, 1);
        checkOutput("vec_a5", outData, 32'h5A5A5A5A);

        // Zero seed substitutes 1
        applyStimulus(0, 1, 32'h0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 32'h12345678, 1);
        checkOutput("vec_zero_seed", outData, 32'h12345679);

        // Round trip at full rate
        key = 32'hDEADBEEF;
        for (int i = 0; i < 1000; i++) begin
            plain[i]  = $urandom;
            cipher[i] = plain[i] ^ key;
            key       = refAdvance(key);
        end
        applyStimulus(0, 1, 32'hDEADBEEF, 0, 0, 1);
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(0, 0, 0, 1, cipher[i], 1);
            if (outData !== plain[i] || inReady !== 1'b1)
                checkOutput("rt_data", outData, plain[i]);
            else
                checkCount++;
        end
`ifdef DESCRAMBLER_WORD_COUNT_EN
        checkOutput("rt_count", {16'd0, wordCount}, 32'd1000);
`else
        checkOutput("rt_count", {16'd0, wordCount}, 32'd0);
`endif

        // Backpressure: hold output five cycles, then release
        applyStimulus(0, 1, 32'h13579BDF, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 32'h0, 0);
        checkOutput("bp_first", outData, 32'h13579BDF);
        held = outData;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, $urandom, 0);
            checkOutput("bp_held", outData, held);
        end
        applyStimulus(0, 0, 0, 1, 32'h0, 1);
        checkOutput("bp_next_key", outData, refAdvance(32'h13579BDF));

        // Seed load with a held word, then seed load with in_valid
        applyStimulus(0, 0, 0, 1, 32'h0F0F0F0F, 0);
        held = outData;
        applyStimulus(0, 1, 32'h2468ACE0, 1, 32'h0F0F0F0F, 0);
        checkOutput("sl_held", outData, held);
        applyStimulus(0, 1, 32'hC3C3C3C3, 1, 32'h3C3C3C3C, 1);
        applyStimulus(0, 0, 0, 1, 32'h3C3C3C3C, 1);
        checkOutput("sl_new_seed", outData, 32'hFFFFFFFF);

        // Reset mid-stream with a held word
        applyStimulus(0, 0, 0, 1, 32'h55555555, 0);
        applyStimulus(1, 1, 32'h77777777, 1, 32'h55555555, 0);
        checkOutput("rst_valid", {31'd0, outValid}, 32'd0);
        applyStimulus(0, 0, 0, 1, 32'hCAFEF00D, 1);
        checkOutput("rst_restart", outData, 32'hCAFEF00C);

        // Random traffic with occasional seed loads
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            applyStimulus(0, ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                          $urandom_range(0, 1) == 1, w, $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/xor_stream_descrambler.md
# xor_stream_descrambler

Receive-side companion to the datapath XOR stage. It recovers plaintext words from a stream that an upstream unit scrambled by XOR with an LFSR keystream. The block regenerates the same keystream from a shared seed and XORs it onto each incoming 32-bit word. It sits between a valid/ready word source and the consumer, with one registered output stage.

## Interface
Parameters:
- WIDTH, 32, data word width; the keystream generator is defined only for 32.
- POLY, 32'h80200003, Galois LFSR tap mask (x^32+x^22+x^2+x+1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- seed_load  input  1  load seed into the LFSR this cycle.
- seed  input  32  keystream seed value.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  32  scrambled word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  32  descrambled word.
- word_count  output  16  number of words accepted since the last reset or seed load.

## Operation
- State: 32-bit `lfsr`, output register (`out_data`, `out_valid`), 16-bit `word_count`.
- Reset values:
  - lfsr = 32'h00000001
  - out_valid = 0
  - out_data = 0
  - word_count = 0
- Seed load:
  - When seed_load=1, lfsr <= seed.
  - A seed of 0 is replaced by 32'h00000001, because the all-zero state locks the LFSR.
  - word_count <= 0.
  - in_ready is forced to 0 that cycle, so no word is accepted during a seed load.
  - seed_load has priority over every other update except rst.
- Accept: a word is accepted when in_valid && in_ready.
- Ready rule: in_ready = !seed_load && (!out_valid || out_ready).
- On accept:
  - out_data <= in_data ^ lfsr, using the LFSR state before it advances.
  - out_valid <= 1.
  - lfsr <= lfsr advanced 32 Galois steps.
  - word_count increments.
- One Galois step:
  - If lsb = 1: s = (s >> 1) ^ POLY.
  - Otherwise: s = s >> 1.
- Output retire: when out_valid && out_ready and no new accept occurs, out_valid <= 0. out_data holds its last value.
- Held output: while out_valid && !out_ready, out_data and out_valid stay stable and the LFSR does not advance.
- A seed_load during a held output does not disturb the held word.
- Counter: word_count saturates at 16'hFFFF and does not wrap.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word/cycle when out_ready is held high; no bubbles.
- Simultaneous retire and accept in the same cycle: the new word replaces the old one and out_valid stays 1.
- rst asserted mid-stream: the next cycle shows every output at its reset value, and any held word is discarded.
- seed_load and rst asserted together: rst wins.
- Accept on the cycle after a seed load: uses the new seed as its keystream word.

## Configuration
- DESCRAMBLER_WORD_COUNT_EN
  - Defined: the word_count counter is built as described above.
  - Undefined: the counter logic is omitted and word_count is tied to 16'h0000.
  - Data behaviour is identical in both builds.

## Structure
- Shared package holds:
  - LFSR_POLY (default for POLY)
  - LFSR_ZERO_SUB (32'h00000001)
  - WORD_W (32)
  - The 32-step advance function `lfsr_adv32`, so the upstream scrambler uses an identical definition.
- One sub-module, `lfsr32_keygen`, owns:
  - the lfsr register
  - seed load with zero substitution
  - advance-on-enable
- The top level keeps the handshake, the output register, the XOR and the counter.

## Test plan
- Reset then seed_load with seed=32'hA5A5A5A5; accept in_data=32'hFFFFFFFF -> out_data=32'h5A5A5A5A one cycle later, word_count=1.
- seed_load with seed=0; accept in_data=32'h12345678 -> out_data=32'h12345679, which shows the zero-seed substitution.
- Round trip: scramble 1000 random words with a reference model using seed 32'hDEADBEEF and feed them at full rate with out_ready=1 -> outputs match the originals, no bubbles, word_count=1000.
- Backpressure: hold out_ready=0 for 5 cycles with a word pending -> in_ready=0, out_data stable; release -> the next word uses the next keystream word, with no skip and no repeat.
- seed_load asserted together with in_valid=1 -> in_ready=0 and the word is not consumed; it is accepted on the next cycle using the new seed.
- rst mid-stream while out_valid=1 -> the next cycle shows out_valid=0, word_count=0 and lfsr restarting from 32'h00000001.
